vxe_axi4mst_biu: RTL and testbench
==================================

# vxe_axi4mst_biu

AXI4 master bus interface unit: converts a simple request/response BIU interface into single-beat AXI4 read and write transactions. Sits between an internal requester (DMA or vector load/store path) and the system interconnect. It is the initiator counterpart of the vxe_axi4slv_biu slave. Read and write paths are independent, with at most one outstanding transaction per path.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (power of two, ≥8)
- ID_WIDTH, 8, AXI ID width
- RD_ID, 1, constant ARID value
- WR_ID, 2, constant AWID value
- PROT, 3'b000, constant ARPROT/AWPROT value

Ports:
- M_AXI4_ACLK  in  1  clock
- M_AXI4_ARESETn  in  1  reset, asynchronous, active-low
- M_AXI4_AW{ID,ADDR,LEN,SIZE,BURST,LOCK,PROT,VALID}  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/3/1  write address channel
- M_AXI4_AWREADY  in  1
- M_AXI4_W{DATA,STRB,LAST,VALID}  out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
- M_AXI4_WREADY  in  1
- M_AXI4_B{ID,RESP,VALID}  in  ID_WIDTH/2/1; M_AXI4_BREADY  out  1
- M_AXI4_AR{ID,ADDR,LEN,SIZE,BURST,LOCK,PROT,VALID}  out  as AW; M_AXI4_ARREADY  in  1
- M_AXI4_R{ID,DATA,RESP,LAST,VALID}  in  ID_WIDTH/DATA_WIDTH/2/1/1; M_AXI4_RREADY  out  1
- biu_rreq  in  1  read request; biu_raddr  in  ADDR_WIDTH
- biu_rgnt  out  1  read request accepted this cycle
- biu_rvalid  out  1  read response pulse; biu_rdata  out  DATA_WIDTH; biu_rerror  out  1
- biu_wreq  in  1; biu_waddr  in  ADDR_WIDTH; biu_wdata  in  DATA_WIDTH; biu_wben  in  DATA_WIDTH/8
- biu_wgnt  out  1  write request accepted this cycle
- biu_wdone  out  1  write response pulse; biu_werror  out  1

## Operation
- Constant outputs: LEN=0, SIZE=log2(DATA_WIDTH/8), BURST=INCR (2'b01), LOCK=0, WLAST=1, IDs/PROT from parameters.
- Read FSM: R_IDLE → R_ADDR → R_DATA → R_IDLE.
  - R_IDLE: biu_rgnt = biu_rreq (combinational); on grant, register raddr → R_ADDR.
  - R_ADDR: ARVALID=1, held stable until ARREADY; then → R_DATA.
  - R_DATA: RREADY=1; on RVALID: capture RDATA; error = RRESP[1]; → R_IDLE.
  - biu_rvalid pulses one cycle after the R handshake, with biu_rdata/biu_rerror valid in the same cycle. biu_rdata holds its value until the next response.
- Write FSM: W_IDLE → W_XFER → W_RESP → W_IDLE.
  - W_IDLE: biu_wgnt = biu_wreq; on grant, register waddr/wdata/wben → W_XFER.
  - W_XFER: AWVALID and WVALID are both raised. Each drops independently after its own handshake. Leave the state when both are done, whether they complete in the same cycle or in either order.
  - W_RESP: BREADY=1; on BVALID: error = BRESP[1] → W_IDLE.
  - biu_wdone/biu_werror pulse one cycle after the B handshake.
- Paths are fully concurrent; a read and a write may be granted in the same cycle.
- RESP decoding: OKAY/EXOKAY = success; SLVERR/DECERR = error.

## Timing
- Reset values: all VALID/READY outputs 0, biu_rvalid/biu_wdone/biu_rerror/biu_werror 0, biu_rdata 0, ADDR/WDATA/WSTRB 0, FSMs idle.
- Best-case read latency: grant at cycle 0 → ARVALID at cycle 1 → (ARREADY at cycle 1) R accepted at cycle 2 → biu_rvalid at cycle 3.
- Best-case write latency: grant at cycle 0 → AW/W at cycle 1 → B at cycle 2 → biu_wdone at cycle 3.
- Grants are only possible in the idle state, so back-to-back throughput is one transaction per 3 cycles per path.
- VALID signals never drop before their handshake completes (AXI rule). Addresses and data are stable while VALID is high.
- Responses arriving with READY low are ignored by the slave protocol. This block never holds READY high outside R_DATA/W_RESP.
- Reset asserted mid-transaction: immediate return to idle, all valids drop, no response pulse.

## Configuration
- VXE_AXI4MST_RESP_CHECK_EN defined:
  - RID≠RD_ID, BID≠WR_ID, or RLAST=0 on the accepted beat forces biu_rerror/biu_werror=1 for that response.
  - The transaction still completes normally.
- VXE_AXI4MST_RESP_CHECK_EN undefined: RID/BID/RLAST are ignored, and error reflects RESP only.

## Test plan
- Read, ARREADY=1 and RVALID one cycle after AR, raddr=0x0000_000C, RDATA=0xFEFE_FAFA, RRESP=OKAY → ARADDR=0xC, ARID=1, biu_rvalid pulse with 0xFEFE_FAFA, rerror=0, 3-cycle latency.
- Read with ARREADY delayed 3 cycles, RRESP=SLVERR → ARVALID/ARADDR held stable for 4 cycles, biu_rerror=1 with the response.
- Write, AWREADY at cycle 1 and WREADY at cycle 3, waddr=0x10, wdata=0xF5F6_F7F8, wben=0xF → AWVALID drops after cycle 1, WVALID after cycle 3, BREADY from cycle 4, biu_wdone=1 with werror=0 after BVALID.
- Simultaneous read grant (0x80) and write grant (0x30, 0xF7F7_F7F7) → both complete independently with correct IDs (1 and 2) and one pulse each.
- Reset asserted while in R_DATA and W_XFER → ARVALID/AWVALID/WVALID/RREADY all 0 immediately, no biu_rvalid/biu_wdone.
- With VXE_AXI4MST_RESP_CHECK_EN: RID=3, RRESP=OKAY → biu_rerror=1. Without the macro, the same stimulus → biu_rerror=0.

Source files
------------

// File: rtl/vxe_axi4mst_biu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vxe_axi4mst_biu
// Purpose  : AXI4 master bus interface unit. Turns a simple request/grant
//            BIU interface into single-beat AXI4 read and write transactions.
//            Read and write paths are independent; each path carries at most
//            one outstanding transaction.
// Options  : VXE_AXI4MST_RESP_CHECK_EN - also flag RID/BID mismatch and a
//            missing RLAST as response errors.
// Revision : 1.0 - initial release
// ============================================================================
module vxe_axi4mst_biu #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned RD_ID      = 1,
    parameter int unsigned WR_ID      = 2,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                    M_AXI4_ACLK,
    input  logic                    M_AXI4_ARESETn,
    // write address channel
    output logic [ID_WIDTH-1:0]     M_AXI4_AWID,
    output logic [ADDR_WIDTH-1:0]   M_AXI4_AWADDR,
    output logic [7:0]              M_AXI4_AWLEN,
    output logic [2:0]              M_AXI4_AWSIZE,
    output logic [1:0]              M_AXI4_AWBURST,
    output logic                    M_AXI4_AWLOCK,
    output logic [2:0]              M_AXI4_AWPROT,
    output logic                    M_AXI4_AWVALID,
    input  logic                    M_AXI4_AWREADY,
    // write data channel
    output logic [DATA_WIDTH-1:0]   M_AXI4_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI4_WSTRB,
    output logic                    M_AXI4_WLAST,
    output logic                    M_AXI4_WVALID,
    input  logic                    M_AXI4_WREADY,
    // write response channel
    input  logic [ID_WIDTH-1:0]     M_AXI4_BID,
    input  logic [1:0]              M_AXI4_BRESP,
    input  logic                    M_AXI4_BVALID,
    output logic                    M_AXI4_BREADY,
    // read address channel
    output logic [ID_WIDTH-1:0]     M_AXI4_ARID,
    output logic [ADDR_WIDTH-1:0]   M_AXI4_ARADDR,
    output logic [7:0]              M_AXI4_ARLEN,
    output logic [2:0]              M_AXI4_ARSIZE,
    output logic [1:0]              M_AXI4_ARBURST,
    output logic                    M_AXI4_ARLOCK,
    output logic [2:0]              M_AXI4_ARPROT,
    output logic                    M_AXI4_ARVALID,
    input  logic                    M_AXI4_ARREADY,
    // read data channel
    input  logic [ID_WIDTH-1:0]     M_AXI4_RID,
    input  logic [DATA_WIDTH-1:0]   M_AXI4_RDATA,
    input  logic [1:0]              M_AXI4_RRESP,
    input  logic                    M_AXI4_RLAST,
    input  logic                    M_AXI4_RVALID,
    output logic                    M_AXI4_RREADY,
    // internal read request/response
    input  logic                    biu_rreq,
    input  logic [ADDR_WIDTH-1:0]   biu_raddr,
    output logic                    biu_rgnt,
    output logic                    biu_rvalid,
    output logic [DATA_WIDTH-1:0]   biu_rdata,
    output logic                    biu_rerror,
    // internal write request/response
    input  logic                    biu_wreq,
    input  logic [ADDR_WIDTH-1:0]   biu_waddr,
    input  logic [DATA_WIDTH-1:0]   biu_wdata,
    input  logic [DATA_WIDTH/8-1:0] biu_wben,
    output logic                    biu_wgnt,
    output logic                    biu_wdone,
    output logic                    biu_werror
);

    localparam int unsigned          c_strb_w     = DATA_WIDTH / 8;
    localparam logic [2:0]           c_size       = 3'($clog2(c_strb_w));
    localparam logic [1:0]           c_burst_incr = 2'b01;
    localparam logic [ID_WIDTH-1:0]  c_rd_id      = ID_WIDTH'(RD_ID);
    localparam logic [ID_WIDTH-1:0]  c_wr_id      = ID_WIDTH'(WR_ID);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    rd_state_t               r_rd_state;
    rd_state_t               w_rd_state_nxt;
    wr_state_t               r_wr_state;
    wr_state_t               w_wr_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_rvalid;
    logic                    r_rerror;

    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_strb_w-1:0]     r_wstrb;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_wdone;
    logic                    r_werror;

    logic                    w_r_hs;
    logic                    w_b_hs;
    logic                    w_rd_err;
    logic                    w_wr_err;
    logic                    w_unused_inputs;

    // Single-beat INCR transactions: burst attributes never change.
    assign M_AXI4_AWID    = c_wr_id;
    assign M_AXI4_AWLEN   = 8'd0;
    assign M_AXI4_AWSIZE  = c_size;
    assign M_AXI4_AWBURST = c_burst_incr;
    assign M_AXI4_AWLOCK  = 1'b0;
    assign M_AXI4_AWPROT  = PROT;
    assign M_AXI4_WLAST   = 1'b1;
    assign M_AXI4_ARID    = c_rd_id;
    assign M_AXI4_ARLEN   = 8'd0;
    assign M_AXI4_ARSIZE  = c_size;
    assign M_AXI4_ARBURST = c_burst_incr;
    assign M_AXI4_ARLOCK  = 1'b0;
    assign M_AXI4_ARPROT  = PROT;

    assign M_AXI4_ARADDR  = r_araddr;
    assign M_AXI4_AWADDR  = r_awaddr;
    assign M_AXI4_WDATA   = r_wdata;
    assign M_AXI4_WSTRB   = r_wstrb;

    assign biu_rvalid     = r_rvalid;
    assign biu_rdata      = r_rdata;
    assign biu_rerror     = r_rerror;
    assign biu_wdone      = r_wdone;
    assign biu_werror     = r_werror;

    // Handshakes qualified by state so READY is never assumed high elsewhere.
    assign w_r_hs = (r_rd_state == R_DATA) & M_AXI4_RVALID;
    assign w_b_hs = (r_wr_state == W_RESP) & M_AXI4_BVALID;

`ifdef VXE_AXI4MST_RESP_CHECK_EN
    // SLVERR/DECERR, a foreign ID or a missing RLAST all count as an error.
    assign w_rd_err = M_AXI4_RRESP[1] | (M_AXI4_RID != c_rd_id) | ~M_AXI4_RLAST;
    assign w_wr_err = M_AXI4_BRESP[1] | (M_AXI4_BID != c_wr_id);
    assign w_unused_inputs = ^{M_AXI4_RRESP[0], M_AXI4_BRESP[0]};
`else
    // Only SLVERR/DECERR (RESP[1] set) count as an error.
    assign w_rd_err = M_AXI4_RRESP[1];
    assign w_wr_err = M_AXI4_BRESP[1];
    assign w_unused_inputs = ^{M_AXI4_RRESP[0], M_AXI4_BRESP[0],
                               M_AXI4_RID, M_AXI4_RLAST, M_AXI4_BID};
`endif

    // Read FSM state register.
    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    // Read FSM next state, grant and AR/R handshake outputs.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        biu_rgnt       = 1'b0;
        M_AXI4_ARVALID = 1'b0;
        M_AXI4_RREADY  = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                biu_rgnt = biu_rreq;
                if (biu_rreq) begin
                    w_rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                M_AXI4_ARVALID = 1'b1;
                if (M_AXI4_ARREADY) begin
                    w_rd_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                M_AXI4_RREADY = 1'b1;
                if (M_AXI4_RVALID) begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: begin
                w_rd_state_nxt = R_IDLE;
            end
        endcase
    end

    // Read datapath: latch address on grant, capture data and pulse on R handshake.
    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn) begin
            r_araddr <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_rerror <= 1'b0;
        end else begin
            if (biu_rgnt) begin
                r_araddr <= biu_raddr;
            end
            if (w_r_hs) begin
                r_rdata <= M_AXI4_RDATA;
            end
            r_rvalid <= w_r_hs;
            r_rerror <= w_r_hs & w_rd_err;
        end
    end

    // Write FSM state register.
    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    // Write FSM next state, grant and AW/W/B handshake outputs.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        biu_wgnt       = 1'b0;
        M_AXI4_AWVALID = 1'b0;
        M_AXI4_WVALID  = 1'b0;
        M_AXI4_BREADY  = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                biu_wgnt = biu_wreq;
                if (biu_wreq) begin
                    w_wr_state_nxt = W_XFER;
                end
            end
            W_XFER: begin
                // AW and W retire independently; move on once both have.
                M_AXI4_AWVALID = ~r_aw_done;
                M_AXI4_WVALID  = ~r_w_done;
                if ((r_aw_done | M_AXI4_AWREADY) & (r_w_done | M_AXI4_WREADY)) begin
                    w_wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                M_AXI4_BREADY = 1'b1;
                if (M_AXI4_BVALID) begin
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: begin
                w_wr_state_nxt = W_IDLE;
            end
        endcase
    end

    // Remember which of AW/W has already handshaken in the current transfer.
    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if ((r_wr_state != W_XFER) || (w_wr_state_nxt != W_XFER)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (M_AXI4_AWREADY) begin
                r_aw_done <= 1'b1;
            end
            if (M_AXI4_WREADY) begin
                r_w_done <= 1'b1;
            end
        end
    end

    // Write datapath: latch request on grant, pulse completion on B handshake.
    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_wdone  <= 1'b0;
            r_werror <= 1'b0;
        end else begin
            if (biu_wgnt) begin
                r_awaddr <= biu_waddr;
                r_wdata  <= biu_wdata;
                r_wstrb  <= biu_wben;
            end
            r_wdone  <= w_b_hs;
            r_werror <= w_b_hs & w_wr_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vxe_axi4mst_biu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vxe_axi4mst_biu
// Purpose  : Self-checking bench for vxe_axi4mst_biu. A reactive AXI slave
//            model with per-transaction delays, a scoreboard of expected
//            responses, a vector table and hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vxe_axi4mst_biu;

`ifdef VXE_AXI4MST_RESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  awid, arid, bid = '0, rid = '0;
    logic [31:0] awaddr, araddr, wdata, rdata = '0;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp = '0, rresp = '0;
    logic        awlock, arlock, awvalid, arvalid, wlast, wvalid, bready, rready;
    logic [3:0]  wstrb;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0;
    logic        rvalid = 1'b0, rlast = 1'b0;

    logic        biu_rreq = 1'b0, biu_wreq = 1'b0;
    logic [31:0] biu_raddr = '0, biu_waddr = '0, biu_wdata = '0;
    logic [3:0]  biu_wben = '0;
    logic        biu_rgnt, biu_rvalid, biu_rerror, biu_wgnt, biu_wdone, biu_werror;
    logic [31:0] biu_rdata;

    vxe_axi4mst_biu dut (
        .M_AXI4_ACLK(clk), .M_AXI4_ARESETn(rst_n),
        .M_AXI4_AWID(awid), .M_AXI4_AWADDR(awaddr), .M_AXI4_AWLEN(awlen),
        .M_AXI4_AWSIZE(awsize), .M_AXI4_AWBURST(awburst), .M_AXI4_AWLOCK(awlock),
        .M_AXI4_AWPROT(awprot), .M_AXI4_AWVALID(awvalid), .M_AXI4_AWREADY(awready),
        .M_AXI4_WDATA(wdata), .M_AXI4_WSTRB(wstrb), .M_AXI4_WLAST(wlast),
        .M_AXI4_WVALID(wvalid), .M_AXI4_WREADY(wready),
        .M_AXI4_BID(bid), .M_AXI4_BRESP(bresp), .M_AXI4_BVALID(bvalid), .M_AXI4_BREADY(bready),
        .M_AXI4_ARID(arid), .M_AXI4_ARADDR(araddr), .M_AXI4_ARLEN(arlen),
        .M_AXI4_ARSIZE(arsize), .M_AXI4_ARBURST(arburst), .M_AXI4_ARLOCK(arlock),
        .M_AXI4_ARPROT(arprot), .M_AXI4_ARVALID(arvalid), .M_AXI4_ARREADY(arready),
        .M_AXI4_RID(rid), .M_AXI4_RDATA(rdata), .M_AXI4_RRESP(rresp), .M_AXI4_RLAST(rlast),
        .M_AXI4_RVALID(rvalid), .M_AXI4_RREADY(rready),
        .biu_rreq(biu_rreq), .biu_raddr(biu_raddr), .biu_rgnt(biu_rgnt),
        .biu_rvalid(biu_rvalid), .biu_rdata(biu_rdata), .biu_rerror(biu_rerror),
        .biu_wreq(biu_wreq), .biu_waddr(biu_waddr), .biu_wdata(biu_wdata), .biu_wben(biu_wben),
        .biu_wgnt(biu_wgnt), .biu_wdone(biu_wdone), .biu_werror(biu_werror)
    );

    // Vector record: request, slave behaviour, expected result.
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;     // read: slave RDATA, write: biu_wdata
        logic [3:0]  ben;
        int          d1;       // read: ARREADY delay, write: AWREADY delay
        int          d2;       // read: RVALID delay,  write: WREADY delay
        int          d3;       // write: BVALID delay
        logic [1:0]  resp;
        logic [7:0]  id;
        bit          last;
        bit          exp_err;
        int          exp_lat;  // cycles from grant to response pulse
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  ben;
        bit          err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_rv  = 0;
    int n_wd  = 0;

    // Slave behaviour for the transaction in flight.
    int          cfg_ar_dly = 0, cfg_r_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = '0, cfg_bresp = '0;
    logic [7:0]  cfg_rid = 8'd1, cfg_bid = 8'd2;
    bit          cfg_rlast = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave model + monitor, evaluated on the falling edge.
    int   ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    bit   r_pend = 0, r_fin = 0, aw_got = 0, w_got = 0, b_pend = 0, b_fin = 0;
    bit   pv_ar = 0, pv_aw = 0, pv_w = 0;
    logic [31:0] pv_araddr = '0, pv_awaddr = '0, pv_wdata = '0;
    exp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
            r_pend = 0; r_fin = 0; aw_got = 0; w_got = 0; b_pend = 0; b_fin = 0;
            pv_ar = 0; pv_aw = 0; pv_w = 0;
        end else begin
            // responses back to the requester
            if (biu_rvalid) begin
                n_rv++;
                if (rd_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'(biu_rvalid), 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    chk("rdata", biu_rdata, e.data);
                    chk("rerror", 32'(biu_rerror), 32'(e.err));
                    chk("rd_latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end
            if (biu_wdone) begin
                n_wd++;
                if (wr_q.size() == 0) begin
                    chk("wdone_unexpected", 32'(biu_wdone), 32'd0);
                end else begin
                    e = wr_q.pop_front();
                    chk("werror", 32'(biu_werror), 32'(e.err));
                    chk("wr_latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end
            // VALID/payload stable while waiting for READY
            if (pv_ar) begin
                chk("arvalid_hold", 32'(arvalid), 32'd1);
                chk("araddr_hold", araddr, pv_araddr);
            end
            if (pv_aw) begin
                chk("awvalid_hold", 32'(awvalid), 32'd1);
                chk("awaddr_hold", awaddr, pv_awaddr);
            end
            if (pv_w) begin
                chk("wvalid_hold", 32'(wvalid), 32'd1);
                chk("wdata_hold", wdata, pv_wdata);
            end
            // R channel
            if (r_fin) begin
                rvalid = 0; r_fin = 0; r_pend = 0;
            end else if (r_pend) begin
                if (r_cnt >= cfg_r_dly) begin
                    rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp;
                    rid = cfg_rid; rlast = cfg_rlast;
                end
                r_cnt++;
            end
            if (rvalid && rready) r_fin = 1;
            // B channel
            if (b_fin) begin
                bvalid = 0; b_fin = 0; b_pend = 0;
            end else if (b_pend) begin
                if (b_cnt >= cfg_b_dly) begin
                    bvalid = 1; bresp = cfg_bresp; bid = cfg_bid;
                end
                b_cnt++;
            end
            if (bvalid && bready) b_fin = 1;
            // address / write data readiness
            if (arvalid) begin arready = (ar_cnt >= cfg_ar_dly); ar_cnt++; end
            else begin arready = 0; ar_cnt = 0; end
            if (awvalid) begin awready = (aw_cnt >= cfg_aw_dly); aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= cfg_w_dly); w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
            // handshakes that complete on the next rising edge
            if (arvalid && arready) begin
                r_pend = 1; r_cnt = 0;
                if (rd_q.size() != 0) chk("araddr", araddr, rd_q[0].addr);
                chk("arid", 32'(arid), 32'd1);
                chk("ar_attr", {arlen, 5'd0, arsize, 6'd0, arburst, arlock, arprot},
                               {8'd0, 5'd0, 3'd2, 6'd0, 2'b01, 1'b0, 3'd0});
            end
            if (awvalid && awready) begin
                aw_got = 1;
                if (wr_q.size() != 0) chk("awaddr", awaddr, wr_q[0].addr);
                chk("awid", 32'(awid), 32'd2);
            end
            if (wvalid && wready) begin
                w_got = 1;
                if (wr_q.size() != 0) begin
                    chk("wdata", wdata, wr_q[0].data);
                    chk("wstrb", 32'(wstrb), 32'(wr_q[0].ben));
                end
                chk("wlast", 32'(wlast), 32'd1);
            end
            if (aw_got && w_got) begin
                b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
            end
            pv_ar = arvalid && !arready; pv_araddr = araddr;
            pv_aw = awvalid && !awready; pv_awaddr = awaddr;
            pv_w  = wvalid && !wready;   pv_wdata  = wdata;
        end
    end

    // Issue a read and/or a write in the same cycle and score the grants.
    task automatic drive(input bit do_rd, input vec_t rv, input bit do_wr, input vec_t wv);
        exp_t x;
        @(negedge clk);
        if (do_rd) begin
            cfg_ar_dly = rv.d1; cfg_r_dly = rv.d2; cfg_rdata = rv.data;
            cfg_rresp = rv.resp; cfg_rid = rv.id; cfg_rlast = rv.last;
            biu_rreq = 1; biu_raddr = rv.addr;
        end
        if (do_wr) begin
            cfg_aw_dly = wv.d1; cfg_w_dly = wv.d2; cfg_b_dly = wv.d3;
            cfg_bresp = wv.resp; cfg_bid = wv.id;
            biu_wreq = 1; biu_waddr = wv.addr; biu_wdata = wv.data; biu_wben = wv.ben;
        end
        #1;
        if (do_rd) begin
            chk("rgnt", 32'(biu_rgnt), 32'd1);
            x = '{addr: rv.addr, data: rv.data, ben: 4'h0, err: rv.exp_err, lat: rv.exp_lat, t0: cyc};
            if (biu_rgnt) rd_q.push_back(x);
        end
        if (do_wr) begin
            chk("wgnt", 32'(biu_wgnt), 32'd1);
            x = '{addr: wv.addr, data: wv.data, ben: wv.ben, err: wv.exp_err, lat: wv.exp_lat, t0: cyc};
            if (biu_wgnt) wr_q.push_back(x);
        end
        @(negedge clk);
        biu_rreq = 0; biu_wreq = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("response_timeout", 32'(rd_q.size() + wr_q.size()), 32'd0);
        rd_q.delete();
        wr_q.delete();
        @(negedge clk);
    endtask

    vec_t tbl[10];
    vec_t rv, wv;
    int   rv0, wd0;

    initial begin
        //           wr  addr          data          ben   d1 d2 d3 resp  id    last err  lat
        tbl[0] = '{0, 32'h0000_000C, 32'hFEFE_FAFA, 4'h0, 0, 0, 0, 2'd0, 8'd1, 1, 0,   3};
        tbl[1] = '{0, 32'h0000_0100, 32'h1234_5678, 4'h0, 3, 0, 0, 2'd2, 8'd1, 1, 1,   6};
        tbl[2] = '{1, 32'h0000_0010, 32'hF5F6_F7F8, 4'hF, 0, 2, 0, 2'd0, 8'd2, 1, 0,   5};
        tbl[3] = '{1, 32'h0000_0024, 32'hA5A5_0000, 4'hC, 3, 0, 1, 2'd3, 8'd2, 1, 1,   7};
        tbl[4] = '{0, 32'h0000_0044, 32'hDEAD_BEEF, 4'h0, 1, 2, 0, 2'd1, 8'd1, 1, 0,   6};
        tbl[5] = '{1, 32'h0000_1000, 32'h0BAD_F00D, 4'h3, 1, 1, 2, 2'd1, 8'd2, 1, 0,   6};
        tbl[6] = '{0, 32'h0000_0048, 32'hCAFE_0001, 4'h0, 0, 0, 0, 2'd0, 8'd3, 1, CHK, 3};
        tbl[7] = '{1, 32'h0000_0050, 32'h0000_0077, 4'h1, 0, 0, 0, 2'd0, 8'd5, 1, CHK, 3};
        tbl[8] = '{0, 32'h0000_004C, 32'h1357_9BDF, 4'h0, 0, 1, 0, 2'd0, 8'd1, 0, CHK, 4};
        tbl[9] = '{0, 32'h0000_0050, 32'h000D_ECAF, 4'h0, 2, 0, 0, 2'd3, 8'd1, 1, 1,   5};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_pulses", {28'd0, biu_rvalid, biu_wdone, biu_rerror, biu_werror}, 32'd0);
        chk("rst_rdata", biu_rdata, 32'd0);
        chk("rst_addr", araddr | awaddr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_wstrb", 32'(wstrb), 32'd0);
        chk("aw_attr", {awlen, 5'd0, awsize, 6'd0, awburst, awlock, awprot, wlast},
                       {8'd0, 5'd0, 3'd2, 6'd0, 2'b01, 1'b0, 3'd0, 1'b1});
        rst_n = 1;

        // vector table
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) drive(1'b0, tbl[i], 1'b1, tbl[i]);
            else           drive(1'b1, tbl[i], 1'b0, tbl[i]);
            wait_idle(50);
            if (!tbl[i].wr) chk("rdata_hold", biu_rdata, tbl[i].data);
        end

        // simultaneous read and write grants
        rv = '{0, 32'h0000_0080, 32'h1111_2222, 4'h0, 0, 0, 0, 2'd0, 8'd1, 1, 0, 3};
        wv = '{1, 32'h0000_0030, 32'hF7F7_F7F7, 4'hF, 0, 0, 0, 2'd0, 8'd2, 1, 0, 3};
        rv0 = n_rv; wd0 = n_wd;
        drive(1'b1, rv, 1'b1, wv);
        wait_idle(50);
        repeat (3) @(negedge clk);
        chk("concurrent_rd_pulses", 32'(n_rv - rv0), 32'd1);
        chk("concurrent_wr_pulses", 32'(n_wd - wd0), 32'd1);

        // reset while the read waits in R_DATA and the write in W_XFER
        rv = '{0, 32'h0000_0200, 32'h5555_AAAA, 4'h0, 0, 20, 0, 2'd0, 8'd1, 1, 0, 23};
        wv = '{1, 32'h0000_0300, 32'h6666_9999, 4'hF, 20, 20, 0, 2'd0, 8'd2, 1, 0, 23};
        drive(1'b1, rv, 1'b1, wv);
        @(negedge clk);
        chk("pre_rst_rready", 32'(rready), 32'd1);
        chk("pre_rst_aw_w", {30'd0, awvalid, wvalid}, 32'd3);
        #2 rst_n = 0;
        #1;
        chk("async_rst_valids", {28'd0, arvalid, awvalid, wvalid, rready}, 32'd0);
        rd_q.delete();
        wr_q.delete();
        rv0 = n_rv; wd0 = n_wd;
        repeat (2) @(negedge clk);
        chk("rst_rdata_cleared", biu_rdata, 32'd0);
        chk("rst_awaddr_cleared", awaddr, 32'd0);
        rst_n = 1;
        repeat (8) @(negedge clk);
        chk("no_pulse_after_rst", 32'((n_rv - rv0) + (n_wd - wd0)), 32'd0);

        // the paths still work after the mid-transaction reset
        drive(1'b1, tbl[0], 1'b0, tbl[0]);
        wait_idle(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
